// File: rtl/fb_port_sched.sv
// fb_port_sched: shares the single frame_buf port between the scanout reader,
// which has priority, and a rectangle-fill engine. A starvation counter forces
// a fill write through after a bounded run of blocked cycles.
module fb_port_sched #(
    parameter int RD_LATENCY   = 1,
    parameter int STARVE_LIMIT = 15
) (
    input  logic        clk_clk,
    input  logic        reset_reset,
    input  logic        rd_req,
    input  logic [16:0] rd_addr,
    output logic        rd_ready,
    output logic        rd_valid,
    output logic [31:0] rd_data,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [16:0] cmd_base,
    input  logic [7:0]  cmd_width,
    input  logic [7:0]  cmd_height,
    input  logic [8:0]  cmd_stride,
    input  logic [31:0] cmd_color,
    input  logic [3:0]  cmd_byteenable,
    output logic        busy,
    output logic        done,
    output logic [16:0] fb_address,
    output logic        fb_chipselect,
    output logic        fb_clken,
    output logic        fb_write,
    output logic [31:0] fb_writedata,
    output logic [3:0]  fb_byteenable,
    input  logic [31:0] fb_readdata
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_DONE
    } state_t;

    localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);

    state_t                state;
    logic [7:0]            col;
    logic [7:0]            row;
    logic [16:0]           row_base;
    logic [7:0]            width;
    logic [7:0]            height;
    logic [8:0]            stride;
    logic [31:0]           color;
    logic [3:0]            byteenable;
    logic [7:0]            starve_cnt;
    logic [RD_LATENCY-1:0] valid_pipe;

    logic                  fill_want;
    logic                  force_wr;
    logic                  read_grant;
    logic                  write_grant;
    logic                  last_col;
    logic                  last_row;
    logic [16:0]           fill_addr;

    assign fill_want   = (state == ST_FILL);
    assign force_wr    = fill_want && (starve_cnt == STARVE_MAX);
    assign read_grant  = rd_req && !force_wr;
    assign write_grant = fill_want && !read_grant;

    assign fill_addr   = row_base + {9'd0, col};
    assign last_col    = (col == width - 8'd1);
    assign last_row    = (row == height - 8'd1);

    assign rd_ready    = !force_wr;
    assign cmd_ready   = (state == ST_IDLE);
    assign busy        = (state != ST_IDLE);
    assign done        = (state == ST_DONE);
    assign fb_clken    = 1'b1;
    assign rd_data     = fb_readdata;
    assign rd_valid    = valid_pipe[RD_LATENCY-1];

    // Fill engine: latch a command, then walk the rectangle one granted write at a time.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state      <= ST_IDLE;
            col        <= 8'd0;
            row        <= 8'd0;
            row_base   <= 17'd0;
            width      <= 8'd0;
            height     <= 8'd0;
            stride     <= 9'd0;
            color      <= 32'd0;
            byteenable <= 4'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        col        <= 8'd0;
                        row        <= 8'd0;
                        row_base   <= cmd_base;
                        width      <= cmd_width;
                        height     <= cmd_height;
                        stride     <= cmd_stride;
                        color      <= cmd_color;
                        byteenable <= cmd_byteenable;
                        if (cmd_width == 8'd0 || cmd_height == 8'd0) begin
                            state <= ST_DONE;
                        end else begin
                            state <= ST_FILL;
                        end
                    end
                end
                ST_FILL: begin
                    if (write_grant) begin
                        if (last_col) begin
                            col      <= 8'd0;
                            row      <= row + 8'd1;
                            row_base <= row_base + {8'd0, stride};
                            if (last_row) begin
                                state <= ST_DONE;
                            end
                        end else begin
                            col <= col + 8'd1;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Count consecutive cycles a pending fill loses the port to scanout.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            starve_cnt <= 8'd0;
        end else if (!fill_want || write_grant) begin
            starve_cnt <= 8'd0;
        end else if (read_grant) begin
            starve_cnt <= starve_cnt + 8'd1;
        end
    end

    generate
        if (RD_LATENCY == 1) begin : g_lat1
            // Single-stage valid tracking for a one-cycle memory.
            always_ff @(posedge clk_clk) begin
                if (reset_reset) begin
                    valid_pipe <= '0;
                end else begin
                    valid_pipe <= read_grant;
                end
            end
        end else begin : g_latn
            // Multi-stage valid tracking matching the memory read latency.
            always_ff @(posedge clk_clk) begin
                if (reset_reset) begin
                    valid_pipe <= '0;
                end else begin
                    valid_pipe <= {valid_pipe[RD_LATENCY-2:0], read_grant};
                end
            end
        end
    endgenerate

    // Drive the shared memory port from whichever requester holds the grant.
    always_comb begin
        fb_address    = fill_addr;
        fb_chipselect = 1'b0;
        fb_write      = 1'b0;
        fb_writedata  = color;
        fb_byteenable = 4'hF;
        if (read_grant) begin
            fb_address    = rd_addr;
            fb_chipselect = 1'b1;
        end else if (write_grant) begin
            fb_chipselect = 1'b1;
            fb_write      = 1'b1;
            fb_byteenable = byteenable;
        end
    end

endmodule

// File: doc/fb_port_sched.md
# fb_port_sched

Frame-buffer port scheduler. It shares the single frame_buf on-chip memory port between two requesters: the video scanout reader, which has priority, and a built-in rectangle-fill engine that paints snake cells and clears the board. A starvation limit guarantees that fills always make progress. It sits between the scanout/draw logic and the frame_buf slave port of the system.

## Interface
- RD_LATENCY, 1: frame_buf read latency in cycles, legal values 1–2; sets the delay to rd_valid.
- STARVE_LIMIT, 15: consecutive fill-blocked cycles before a fill write is forced, range 1–255.
- clk_clk  in  1  single clock domain.
- reset_reset  in  1  synchronous, active-high reset.
- rd_req  in  1  scanout read request.
- rd_addr  in  17  scanout word address.
- rd_ready  out  1  scanout may be accepted this cycle; a read is accepted when rd_req && rd_ready.
- rd_valid  out  1  rd_data valid; one pulse per accepted read.
- rd_data  out  32  read data, equal to fb_readdata.
- cmd_valid  in  1  fill command valid.
- cmd_ready  out  1  fill engine idle; a command is accepted when cmd_valid && cmd_ready.
- cmd_base  in  17  first word address.
- cmd_width  in  8  words per row; 0 means an empty command.
- cmd_height  in  8  rows; 0 means an empty command.
- cmd_stride  in  9  word distance between row starts.
- cmd_color  in  32  write data.
- cmd_byteenable  in  4  byte enables for every fill write.
- busy  out  1  fill engine not idle.
- done  out  1  one-cycle pulse when a command completes.
- fb_address  out  17  frame_buf address.
- fb_chipselect  out  1  access this cycle.
- fb_clken  out  1  tied to 1.
- fb_write  out  1  write strobe.
- fb_writedata  out  32  write data.
- fb_byteenable  out  4  byte enables; 4'hF on reads.
- fb_readdata  in  32  frame_buf read data.

## Operation
- **FSM states:** IDLE, FILL, DONE.
  - cmd_ready = (state==IDLE).
  - busy = (state!=IDLE).
  - done = (state==DONE).
- **IDLE → FILL** on command accept. The engine latches base, width, height, stride, color and byteenable, and sets col=0, row=0, row_base=base.
- **IDLE → DONE** directly if width==0 or height==0. No fb writes are issued.
- **FILL, per granted write:**
  - Write address = row_base + col, modulo 2^17 (wraps 0x1FFFF→0x00000).
  - If col==width-1: col=0, row+=1, row_base+=stride (17-bit wrap).
  - Otherwise col+=1.
  - The write at col==width-1 and row==height-1 is the last write; the FSM then goes to DONE.
- **DONE → IDLE** unconditionally after one cycle.
- **Arbitration** (combinational from registered state):
  - fill_want = (state==FILL).
  - force = fill_want && (starve_cnt==STARVE_LIMIT).
  - rd_ready = !force.
  - Read grant = rd_req && !force.
  - Write grant = fill_want && !(read grant).
- **starve_cnt (8 bits):**
  - +1 when fill_want && read grant.
  - Cleared on write grant or when !fill_want.
  - Never exceeds STARVE_LIMIT.
- **Port drive:**
  - Read grant: fb_address=rd_addr, fb_chipselect=1, fb_write=0, fb_byteenable=4'hF.
  - Write grant: fb_address=fill address, fb_chipselect=1, fb_write=1, fb_writedata=color, fb_byteenable=latched byteenable.
  - Neither: fb_chipselect=0, fb_write=0.
- **Read return:** a RD_LATENCY-deep valid shift register. rd_valid is asserted exactly RD_LATENCY cycles after the accept cycle. rd_data is fb_readdata passed through. Back-to-back accepts give back-to-back rd_valid.
- cmd_valid while busy is ignored; no queueing.

## Timing
- **Reset values:**
  - State IDLE, starve_cnt=0, valid pipe cleared.
  - busy=0, done=0, cmd_ready=1, rd_valid=0, fb_chipselect=0, fb_write=0, fb_clken=1.
- **Reset asserted mid-fill:** the command is abandoned with no done pulse. In-flight rd_valid is dropped. Outputs take reset values in the cycle after the reset edge.
- **Fill latency:** command accepted at cycle N.
  - Uncontended: first write at N+1; a W×H rectangle writes on N+1 … N+W·H.
  - done and busy=1 at N+W·H+1; cmd_ready=1 at N+W·H+2.
  - Empty command: done at N+1.
- **Continuous rd_req during FILL:** exactly one write per STARVE_LIMIT+1 cycles; rd_ready is low only in those cycles.
- Scanout reads issued while no fill is active see rd_ready=1 every cycle. The fb port sustains one access per cycle.

## Test plan
- **Uncontended fill:** base=0x100, width=3, height=2, stride=160, color=0xDEADBEEF, be=4'hF, rd_req=0 → writes to 0x100, 0x101, 0x102, 0x1A0, 0x1A1, 0x1A2 on 6 consecutive cycles starting at accept+1; done pulses at accept+7; cmd_ready returns at accept+8.
- **Read latency:** RD_LATENCY=1, memory preloaded with word 0x5 = 0x12345678; rd_req with rd_addr=0x5 for one cycle → rd_valid high exactly 1 cycle later with rd_data=0x12345678; repeat with RD_LATENCY=2 → 2 cycles later.
- **Contention:** STARVE_LIMIT=15, rd_req held high, fill 4×1 → fill writes occur every 16th cycle (4 writes over 64 cycles); rd_ready=0 exactly on those 4 cycles; every accepted read returns rd_valid.
- **Empty command:** width=0, height=5 → no fb_write asserted; done at accept+1; busy low at accept+2.
- **Address wrap:** base=0x1FFFF, width=2, height=2, stride=0x100 → writes to 0x1FFFF, 0x00000, 0x000FF, 0x00100.
- **Reset mid-fill:** assert reset_reset after the 3rd write of a 10×10 fill → no further writes, no done pulse; cmd_ready=1 and busy=0 the next cycle; a new 1×1 command then completes normally.
